i2s_tx: RTL

- I2S transmitter (Philips format) for a DAC or amplifier. It is the playback counterpart of the microphone receive path.
- Accepts stereo PCM samples over a valid/ready stream and buffers one stereo sample.
- Generates bit clock and word select, and serialises each sample MSB-first.
- Sits beside the microphone capture path in the top level and runs in the same 100 MHz system clock domain.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_clk_gen.sv | 48 ++++
 rtl/i2s_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Constants and helpers shared by the I2S transmit and microphone receive paths.
package i2s_pkg;

  // Philips format: the MSB follows the word-select change by one bit clock.
  localparam int PHILIPS_DELAY = 1;

  function automatic int calc_div(input int clk_freq, input int bclk_freq);
    return clk_freq / (2 * bclk_freq);
  endfunction

  function automatic int slot_pos(input int bit_cnt, input int slot_bits);
    return bit_cnt % slot_bits;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: toggles bclk every DIV system clocks and flags the
// system-clock cycle whose edge will produce each bclk rise or fall.
module i2s_clk_gen #(
  parameter int DIV = 33
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = enable_i && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + 1'b1;
    bclk_d    = bclk_q;
    if (!enable_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign rise_o = wrap && !bclk_q;
  assign fall_o = wrap && bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: one-deep stereo hold register feeding
// MSB-first shift registers, with underrun detection at each frame load.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000,
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_BITS    = 32,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] sample_left,
  input  logic [DATA_SIZE-1:0] sample_right,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 i2s_clk,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] underrun_count
);

  localparam int DIV        = calc_div(CLK_FREQ, I2S_CLK_FREQ);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  if (DATA_SIZE > SLOT_BITS - 1) begin : g_size_check
    $error("i2s_tx: DATA_SIZE must not exceed SLOT_BITS-1");
  end

  logic                 bclk, bclk_rise, bclk_fall;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d, bit_nxt;
  logic                 ws_q, ws_d, sd_q, sd_d;
  logic [DATA_SIZE-1:0] shl_q, shl_d, shr_q, shr_d;
  logic [DATA_SIZE-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] ucnt_q, ucnt_d;
  int                   k;

  i2s_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .bclk_o   (bclk),
    .rise_o   (bclk_rise),
    .fall_o   (bclk_fall)
  );

  assign sample_ready = !hold_valid_q;

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    shl_d         = shl_q;
    shr_d         = shr_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_valid_d  = hold_valid_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ucnt_d        = ucnt_q;
    bit_nxt       = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    k             = slot_pos(int'(bit_nxt), SLOT_BITS);

    if (!enable) begin
      bit_cnt_d = BIT_LAST;
      ws_d      = 1'b0;
      sd_d      = 1'b0;
      shl_d     = '0;
      shr_d     = '0;
    end else if (bclk_fall) begin
      bit_cnt_d = bit_nxt;
      ws_d      = (int'(bit_nxt) >= SLOT_BITS);
      sd_d      = 1'b0;
      if (k >= PHILIPS_DELAY && k < PHILIPS_DELAY + DATA_SIZE) begin
        if (ws_d) begin
          sd_d  = shr_q[DATA_SIZE-1];
          shr_d = shr_q << 1;
        end else begin
          sd_d  = shl_q[DATA_SIZE-1];
          shl_d = shl_q << 1;
        end
      end
      // Frame load happens on the delay bit, so sd is 0 here either way.
      if (bit_nxt == '0) begin
        frame_start_d = 1'b1;
        if (hold_valid_q) begin
          shl_d        = hold_l_q;
          shr_d        = hold_r_q;
          hold_valid_d = 1'b0;
        end else begin
          shl_d      = '0;
          shr_d      = '0;
          underrun_d = 1'b1;
          if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
        end
      end
    end

    if (sample_valid && sample_ready) begin
      hold_l_d     = sample_left;
      hold_r_d     = sample_right;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q     <= BIT_LAST;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      shl_q         <= '0;
      shr_q         <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      shl_q         <= shl_d;
      shr_q         <= shr_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_valid_q  <= hold_valid_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(bclk_rise && bclk_fall));

  assign i2s_clk        = bclk;
  assign i2s_ws         = ws_q;
  assign i2s_sd         = sd_q;
  assign frame_start    = frame_start_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule
